// File: rtl/mux_4_pkg.sv
// Shared select encodings and lane-index helper for the registered 4:1 mux.
package mux_4_pkg;

  // Select is MSB-first: sel=0 addresses the most-significant lane.
  localparam logic [1:0] SEL_LANE3 = 2'b00;
  localparam logic [1:0] SEL_LANE2 = 2'b01;
  localparam logic [1:0] SEL_LANE1 = 2'b10;
  localparam logic [1:0] SEL_LANE0 = 2'b11;

  function automatic logic [1:0] lane_of(input logic [1:0] sel);
    return 2'd3 - sel;
  endfunction

endpackage

// File: rtl/mux_4_sync_if.sv
// Bus bundle for mux_4_sync; out_parity exists only when MUX_4_SYNC_PARITY_EN is defined.
interface mux_4_sync_if #(
  parameter int unsigned WIDTH = 1
);
  logic [4*WIDTH-1:0] in;
  logic [1:0]         sel;
  logic               in_valid;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
`ifdef MUX_4_SYNC_PARITY_EN
  logic               out_parity;

  modport master (output in, sel, in_valid, input out, out_valid, out_parity);
  modport slave  (input in, sel, in_valid, output out, out_valid, out_parity);
`else
  modport master (output in, sel, in_valid, input out, out_valid);
  modport slave  (input in, sel, in_valid, output out, out_valid);
`endif
endinterface

// File: rtl/mux_4_lane.sv
// Combinational WIDTH-bit 4:1 lane select built from two levels of 2:1 muxes.
module mux_4_lane #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [4*WIDTH-1:0] in_i,
  input  logic [1:0]         sel_i,
  output logic [WIDTH-1:0]   lane_o
);
  logic [WIDTH-1:0] lane0, lane1, lane2, lane3;
  logic [WIDTH-1:0] upper, lower;

  assign lane0 = in_i[0*WIDTH +: WIDTH];
  assign lane1 = in_i[1*WIDTH +: WIDTH];
  assign lane2 = in_i[2*WIDTH +: WIDTH];
  assign lane3 = in_i[3*WIDTH +: WIDTH];

  // sel[1] picks the pair {lane3,lane2} or {lane1,lane0}; sel[0] picks within it.
  always_comb begin
    upper  = sel_i[1] ? lane1 : lane3;
    lower  = sel_i[1] ? lane0 : lane2;
    lane_o = sel_i[0] ? lower : upper;
  end
endmodule

// File: rtl/mux_4_sync.sv
// Registered 4:1 multiplexer with valid flag.
// Optional even-parity output enabled by MUX_4_SYNC_PARITY_EN.
module mux_4_sync
  import mux_4_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  mux_4_sync_if.slave  bus
);
  logic [WIDTH-1:0] lane;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;

  mux_4_lane #(.WIDTH(WIDTH)) u_lane (
    .in_i   (bus.in),
    .sel_i  (bus.sel),
    .lane_o (lane)
  );

  always_comb begin
    out_d       = out_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) out_d = lane;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

`ifdef MUX_4_SYNC_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (bus.in_valid) parity_d = ^lane;
  end

  always_ff @(posedge clk) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end

  assign bus.out_parity = parity_q;
`endif
endmodule

// File: tb/tb_mux_4_sync.sv
// Self-checking bench: WIDTH=1 and WIDTH=4 instances plus a five-instance 16:1 cascade.
module tb_mux_4_sync;
  logic clk;
  logic rst;
  int unsigned n_cmp;
  int unsigned n_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mux_4_sync_if #(.WIDTH(1)) b1 ();
  mux_4_sync_if #(.WIDTH(4)) b4 ();
  mux_4_sync #(.WIDTH(1)) u_d1 (.clk(clk), .reset(rst), .bus(b1));
  mux_4_sync #(.WIDTH(4)) u_d4 (.clk(clk), .reset(rst), .bus(b4));

  // 16:1 cascade: four leaves on sel[1:0], one root on sel[3:2] delayed a cycle.
  logic [15:0] c_in;
  logic [3:0]  c_sel;
  logic        c_valid;
  logic [1:0]  csel_hi_q;
  logic [3:0]  leaf_out;
  logic [3:0]  leaf_v;

  always @(posedge clk) csel_hi_q <= c_sel[3:2];

  for (genvar j = 0; j < 4; j++) begin : g_leaf
    mux_4_sync_if #(.WIDTH(1)) lif ();
    assign lif.in       = c_in[4*j +: 4];
    assign lif.sel      = c_sel[1:0];
    assign lif.in_valid = c_valid;
    assign leaf_out[j]  = lif.out[0];
    assign leaf_v[j]    = lif.out_valid;
    mux_4_sync #(.WIDTH(1)) u_leaf (.clk(clk), .reset(rst), .bus(lif));
  end

  mux_4_sync_if #(.WIDTH(1)) bc ();
  assign bc.in       = leaf_out;
  assign bc.sel      = csel_hi_q;
  assign bc.in_valid = leaf_v[0];
  mux_4_sync #(.WIDTH(1)) u_root (.clk(clk), .reset(rst), .bus(bc));

  // Reference model state
  logic [31:0] m1_out, m4_out, mc_out, mc_pend;
  logic        m1_v, m4_v, m4_par, mc_v, mc_pend_v;

  function automatic logic [31:0] pick(input logic [63:0] bus, input int w, input int s);
    logic [63:0] shifted;
    shifted = bus >> (w * (3 - s));
    return 32'(shifted & ((64'd1 << w) - 64'd1));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    logic [31:0] l;
    if (rst) begin
      m1_out = '0; m1_v = 1'b0;
      m4_out = '0; m4_v = 1'b0; m4_par = 1'b0;
      mc_out = '0; mc_v = 1'b0; mc_pend = '0; mc_pend_v = 1'b0;
    end else begin
      m1_v = b1.in_valid;
      if (b1.in_valid) m1_out = pick(64'(b1.in), 1, int'(b1.sel));
      m4_v = b4.in_valid;
      if (b4.in_valid) begin
        l      = pick(64'(b4.in), 4, int'(b4.sel));
        m4_out = l;
        m4_par = ^l;
      end
      mc_v = mc_pend_v;
      if (mc_pend_v) mc_out = mc_pend;
      mc_pend_v = c_valid;
      mc_pend   = 32'((c_in >> (15 - int'(c_sel))) & 16'd1);
    end
    @(posedge clk);
    #1;
    check("d1_out",   32'(b1.out),       m1_out);
    check("d1_valid", 32'(b1.out_valid), 32'(m1_v));
    check("d4_out",   32'(b4.out),       m4_out);
    check("d4_valid", 32'(b4.out_valid), 32'(m4_v));
`ifdef MUX_4_SYNC_PARITY_EN
    check("d4_par",   32'(b4.out_parity), 32'(m4_par));
    check("d4_even",  32'(^{b4.out, b4.out_parity}), 32'd0);
`endif
    check("casc_out",   32'(bc.out),       mc_out);
    check("casc_valid", 32'(bc.out_valid), 32'(mc_v));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    b1.in = 4'b1111; b1.sel = 2'd0; b1.in_valid = 1'b1;
    b4.in = 16'hABCD; b4.sel = 2'd0; b4.in_valid = 1'b1;
    c_in = 16'h0000; c_sel = 4'd0; c_valid = 1'b0;

    // Reset has priority over in_valid
    repeat (2) begin
      tick();
      check("rst_out", 32'(b1.out), 32'd0);
      check("rst_valid", 32'(b1.out_valid), 32'd0);
    end
    rst = 1'b0;
    tick();
    check("post_rst_out", 32'(b1.out), 32'd1);
    check("post_rst_valid", 32'(b1.out_valid), 32'd1);

    // Walk sel over in=1010
    b1.in = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      b1.sel = 2'(s);
      tick();
      check("walk", 32'(b1.out), (s % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Single hot bit
    b1.in = 4'b1000; b1.sel = 2'd0; tick(); check("hot_hi_s0", 32'(b1.out), 32'd1);
    b1.sel = 2'd3;                 tick(); check("hot_hi_s3", 32'(b1.out), 32'd0);
    b1.in = 4'b0001;               tick(); check("hot_lo_s3", 32'(b1.out), 32'd1);

    // Hold: out keeps 1 while in_valid is low
    b1.in_valid = 1'b0; b1.in = 4'b0000;
    repeat (3) begin
      tick();
      check("hold_out", 32'(b1.out), 32'd1);
      check("hold_valid", 32'(b1.out_valid), 32'd0);
    end

    // Wide lanes
    b4.in = 16'hABCD; b4.sel = 2'd0; tick(); check("wide_s0", 32'(b4.out), 32'hA);
`ifdef MUX_4_SYNC_PARITY_EN
    check("wide_par_A", 32'(b4.out_parity), 32'd0);
`endif
    b4.sel = 2'd3; tick(); check("wide_s3", 32'(b4.out), 32'hD);
`ifdef MUX_4_SYNC_PARITY_EN
    check("wide_par_D", 32'(b4.out_parity), 32'd1);
`endif

    // Cascade: 16:1 with two-cycle latency
    c_in = 16'h000F; c_sel = 4'b1110; c_valid = 1'b1;
    tick();
    c_valid = 1'b0;
    tick();
    check("casc_000F", 32'(bc.out), 32'd1);
    check("casc_000F_v", 32'(bc.out_valid), 32'd1);

    // Randomized traffic including mid-stream resets
    for (int i = 0; i < 300; i++) begin
      rst         = ($urandom_range(0, 19) == 0);
      b1.in       = 4'($urandom);
      b1.sel      = 2'($urandom);
      b1.in_valid = ($urandom_range(0, 9) < 7);
      b4.in       = 16'($urandom);
      b4.sel      = 2'($urandom);
      b4.in_valid = ($urandom_range(0, 9) < 7);
      c_in        = 16'($urandom);
      c_sel       = 4'($urandom);
      c_valid     = ($urandom_range(0, 9) < 7);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mux_4_sync.md
Name: mux_4_sync

Overview:
- Registered 4:1 multiplexer. It selects one of four WIDTH-bit lanes from a packed input bus and registers the result.
- Leaf building block for wider select trees. Cascading five 1-bit instances gives a 16:1 mux.
- Select encoding is MSB-first: sel=0 picks the most-significant lane.

Parameters:
- WIDTH, 1, bit width of each of the four lanes and of out.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in  input  4*WIDTH  packed lanes; lane k = in[k*WIDTH +: WIDTH], k=0..3.
- sel  input  2  lane select; selects lane (3 - sel).
- in_valid  input  1  qualifies in/sel for capture this cycle.
- out  output  WIDTH  registered selected lane.
- out_valid  output  1  registered copy of in_valid; high when out was updated by the last edge.

Behaviour:
- Clocking:
  - One clock domain.
  - All state updates on posedge clk only.
  - No combinational path from inputs to outputs.
- Reset: when reset=1 at a posedge, out<=0 and out_valid<=0. Reset has priority over in_valid.
- Select mapping:
  - sel=2'b00 -> lane 3 (in[4*WIDTH-1 -: WIDTH]).
  - sel=2'b01 -> lane 2.
  - sel=2'b10 -> lane 1.
  - sel=2'b11 -> lane 0 (in[WIDTH-1:0]).
- Capture (reset=0, in_valid=1): out<=selected lane, out_valid<=1. Latency is exactly 1 cycle.
- Hold (reset=0, in_valid=0): out keeps its previous value; out_valid<=0.
- Back-to-back valid cycles give one result per cycle, with no bubbles and no backpressure.
- X/unknown sel is not defined behaviour; the bench must drive known values.
- A reset asserted mid-stream discards the in-flight result. The first valid after reset deassertion appears on the following edge.
- Pure selection: no arithmetic and no width conversion.

Optional Feature:
- Macro: MUX_4_SYNC_PARITY_EN.
- Defined:
  - Adds output out_parity (1 bit), registered alongside out.
  - out_parity = XOR-reduce of the selected lane. This is even parity: the XOR of out and out_parity is always 0.
  - Follows the same reset (0), capture and hold rules as out.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package mux_4_pkg:
  - Localparams SEL_LANE3=2'b00, SEL_LANE2=2'b01, SEL_LANE1=2'b10, SEL_LANE0=2'b11.
  - Function lane_of(sel) returning 3-sel.
- Sub-module mux_4_lane:
  - Purely combinational WIDTH-bit 4:1 select.
  - Built as two levels of 2:1 selection:
    - sel[1]=0 chooses the pair {lane3, lane2}; sel[1]=1 chooses {lane1, lane0}.
    - sel[0] then chooses the upper lane (0) or lower lane (1) of that pair.
- mux_4_sync instantiates mux_4_lane and holds the output/valid (and optional parity) registers.

Test Plan (WIDTH=1 unless noted):
- Reset: reset=1 for 2 cycles with in=4'b1111, in_valid=1 -> out=0, out_valid=0. First valid after release appears 1 cycle later.
- Walk sel with in=4'b1010, in_valid=1 every cycle. Expected (out one cycle after sel):
  - sel=0 -> 1
  - sel=1 -> 0
  - sel=2 -> 1
  - sel=3 -> 0
- Single hot bit: in=4'b1000, sel=0 -> out=1; same in, sel=3 -> out=0. in=4'b0001, sel=3 -> out=1.
- Hold: capture out=1, then in_valid=0 with in=4'b0000 for 3 cycles -> out stays 1, out_valid=0.
- Wide lanes, WIDTH=4: in=16'hABCD.
  - sel=0 -> out=4'hA
  - sel=3 -> out=4'hD
  - With MUX_4_SYNC_PARITY_EN: out_parity for 4'hA = 0, for 4'hD = 1.
- Cascade check: five instances forming a 16:1 tree, with in=16'h000F and sel=4'b1110 -> out=1 after 2 cycles.
